muldiv_unit: RTL
================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width (even, >=8).
REQ-002 SHALL have port clk_i  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start_i  input  1  request valid; sampled only in IDLE.
REQ-005 SHALL have port op_i  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL have ports op1_i, op2_i  input  DATA_WIDTH  rs1/rs2 operands.
REQ-007 SHALL have port flush_i  input  1  abort in-flight operation (branch/jump squash).
REQ-008 SHALL have port busy_o  output  1  high while an operation is in flight; drives pipeline stall.
REQ-009 SHALL have port done_o  output  1  one-cycle pulse, result_o valid.
REQ-010 SHALL have port result_o  output  DATA_WIDTH  result; holds value until next done_o.

Function
REQ-011 SHALL implement FSM states IDLE, CALC, DONE.
REQ-012 IDLE with start_i=1 and flush_i=0 SHALL latch op_i/operands, take operand magnitudes for signed ops, and enter CALC (or DONE for fast paths).
REQ-013 CALC SHALL perform one shift-add (multiply) or restoring shift-subtract (divide) step per cycle for exactly DATA_WIDTH cycles, counted by a $clog2(DATA_WIDTH)+1-bit counter, then enter DONE.
REQ-014 DONE SHALL apply sign correction, register result_o, assert done_o for that cycle only, and return to IDLE.
REQ-015 Iterative latency SHALL be DATA_WIDTH+2 cycles from start_i edge to done_o high (34 at default).
REQ-016 busy_o SHALL be high in CALC and DONE, low in IDLE.
REQ-017 MUL SHALL return low DATA_WIDTH bits of the 2*DATA_WIDTH product; MULH/MULHSU/MULHU the high bits with signed*signed, signed*unsigned, unsigned*unsigned interpretation.
REQ-018 DIV/REM SHALL truncate toward zero; remainder sign SHALL follow dividend.
REQ-019 Divide by zero SHALL skip CALC (DONE next cycle): quotient all-ones, remainder = op1_i.
REQ-020 Signed overflow (op1 = most-negative, op2 = -1) SHALL skip CALC: DIV returns op1_i, REM returns 0.
REQ-021 start_i while busy_o=1 SHALL be ignored; no queuing.
REQ-022 flush_i=1 in CALC or DONE SHALL return to IDLE next edge, suppress done_o, leave result_o unchanged; flush_i in IDLE SHALL block a simultaneous start_i.

Reset
REQ-023 rst_ni low SHALL immediately force IDLE, busy_o=0, done_o=0, result_o=0, counter=0, regardless of clock, including mid-operation.
REQ-024 First start_i SHALL be accepted on the first rising edge after rst_ni deasserts.

Configuration
REQ-025 With MULDIV_FAST_MUL_EN defined, multiply ops SHALL compute via a single-cycle combinational 2*DATA_WIDTH product, going IDLE->DONE (done_o 2 cycles after start edge).
REQ-026 Without MULDIV_FAST_MUL_EN, multiply ops SHALL use the iterative CALC path of REQ-013; divide ops are iterative in both builds.

Structure
REQ-027 Package muldiv_pkg SHALL hold the op_i funct3 enum, the FSM state enum, and the OPCODE_OP_M constant (funct7 0000001) used by the main decoder.
REQ-028 No sub-module SHALL be instantiated; datapath and FSM live in muldiv_unit.

Verification
REQ-029 MUL 7 x -3 -> done_o after 34 cycles (2 with FAST_MUL_EN), result 0xFFFFFFEB.
REQ-030 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000.
REQ-031 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14, 34-cycle latency.
REQ-032 DIV 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000, REM -> 0; both done_o 2 cycles after start.
REQ-033 start DIVU, flush_i at cycle 10 -> IDLE next edge, no done_o, result_o unchanged; start_i pulsed while busy -> ignored.
REQ-034 rst_ni low mid-CALC (asynchronous, between edges) -> busy_o, done_o, result_o 0 immediately; new MUL 3x4 after release -> 12.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg -- shared types for the RV32M multiply/divide unit.
//   op_e      : op_i funct3 encoding (MUL..REMU)
//   state_e   : muldiv_unit FSM states
//   OPCODE_OP_M / is_m_ext : funct7 value the main decoder uses to route
//                            OP instructions to this unit
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_DONE = 2'b10
  } state_e;

  localparam logic [6:0] OPCODE_OP_M = 7'b0000001;

  function automatic logic is_m_ext(input logic [6:0] funct7);
    return funct7 == OPCODE_OP_M;
  endfunction

  // funct3[2] separates divide/remainder ops from multiply ops.
  function automatic logic is_div_op(input op_e op);
    return op[2];
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit -- iterative RV32M multiply/divide unit.
//   Multiply: radix-2 shift-add on operand magnitudes, sign fixed at the end.
//   Divide  : restoring shift-subtract on magnitudes, sign fixed at the end.
//   Divide-by-zero and signed overflow bypass CALC.
// Optional build macro: MULDIV_FAST_MUL_EN -- multiply ops use a single-cycle
//   combinational product and go IDLE->DONE directly.
// Ports:
//   clk_i    in   clock
//   rst_ni   in   asynchronous active-low reset
//   start_i  in   request valid (sampled only in IDLE)
//   op_i     in   [2:0] funct3 operation
//   op1_i    in   [DATA_WIDTH-1:0] rs1 operand
//   op2_i    in   [DATA_WIDTH-1:0] rs2 operand
//   flush_i  in   abort in-flight op / block start in IDLE
//   busy_o   out  high in CALC and DONE
//   done_o   out  one-cycle pulse, result_o valid
//   result_o out  [DATA_WIDTH-1:0] result, held until next done_o
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [2:0]            op_i,
  input  logic [DATA_WIDTH-1:0] op1_i,
  input  logic [DATA_WIDTH-1:0] op2_i,
  input  logic                  flush_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] result_o
);

  localparam int unsigned W     = DATA_WIDTH;
  localparam int unsigned CNT_W = $clog2(DATA_WIDTH) + 1;

  state_e            state_q;
  op_e               op_q;
  logic [W-1:0]      hi_q;      // product high half / partial remainder
  logic [W-1:0]      lo_q;      // multiplier -> product low half / dividend -> quotient
  logic [W-1:0]      mcand_q;   // multiplicand or divisor magnitude
  logic              neg_q;     // negate product / quotient at DONE
  logic              neg_r;     // negate remainder at DONE
  logic [CNT_W-1:0]  cnt_q;

  // ---------------- operand decode (IDLE) ----------------
  op_e          op_in;
  logic         op1_signed, op2_signed;
  logic         op1_neg, op2_neg;
  logic [W-1:0] mag1, mag2;
  logic         div_zero, div_ovf;

  always_comb begin
    op_in      = op_e'(op_i);
    op1_signed = 1'b0;
    op2_signed = 1'b0;
    case (op_in)
      OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
        op1_signed = 1'b1;
        op2_signed = 1'b1;
      end
      OP_MULHSU: op1_signed = 1'b1;
      default: ;
    endcase
    op1_neg  = op1_signed & op1_i[W-1];
    op2_neg  = op2_signed & op2_i[W-1];
    mag1     = op1_neg ? (~op1_i + 1'b1) : op1_i;
    mag2     = op2_neg ? (~op2_i + 1'b1) : op2_i;
    div_zero = (op2_i == '0);
    div_ovf  = op1_signed && op2_signed && (op1_i == {1'b1, {(W-1){1'b0}}}) && (op2_i == '1);
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*W-1:0] a_ext, b_ext, fast_prod;
  assign a_ext     = {{W{op1_signed & op1_i[W-1]}}, op1_i};
  assign b_ext     = {{W{op2_signed & op2_i[W-1]}}, op2_i};
  assign fast_prod = a_ext * b_ext;
`endif

  // ---------------- iteration step ----------------
  logic [W:0] mul_sum;
  logic [W:0] div_trial;
  logic       div_ok;

  always_comb begin
    mul_sum   = {1'b0, hi_q} + {1'b0, mcand_q};
    // Partial remainder stays below the divisor, so the shifted value fits in
    // W+1 bits and bit W of the difference is the borrow.
    div_trial = {hi_q, lo_q[W-1]} - {1'b0, mcand_q};
    div_ok    = ~div_trial[W];
  end

  // ---------------- sign correction (DONE) ----------------
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quo_fix, rem_fix, result_next;

  always_comb begin
    prod_fix = neg_q ? (~{hi_q, lo_q} + 1'b1) : {hi_q, lo_q};
    quo_fix  = neg_q ? (~lo_q + 1'b1) : lo_q;
    rem_fix  = neg_r ? (~hi_q + 1'b1) : hi_q;
    case (op_q)
      OP_MUL:                        result_next = prod_fix[W-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  result_next = prod_fix[2*W-1:W];
      OP_DIV, OP_DIVU:               result_next = quo_fix;
      default:                       result_next = rem_fix;
    endcase
  end

  assign busy_o = (state_q != S_IDLE);

  // ---------------- FSM + datapath ----------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      op_q     <= OP_MUL;
      hi_q     <= '0;
      lo_q     <= '0;
      mcand_q  <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      cnt_q    <= '0;
      done_o   <= 1'b0;
      result_o <= '0;
    end else begin
      done_o <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i && !flush_i) begin
            op_q  <= op_in;
            cnt_q <= '0;
            if (is_div_op(op_in)) begin
              if (div_zero) begin
                // Quotient all-ones, remainder is the raw dividend.
                hi_q    <= op1_i;
                lo_q    <= '1;
                neg_q   <= 1'b0;
                neg_r   <= 1'b0;
                state_q <= S_DONE;
              end else if (div_ovf) begin
                hi_q    <= '0;
                lo_q    <= op1_i;
                neg_q   <= 1'b0;
                neg_r   <= 1'b0;
                state_q <= S_DONE;
              end else begin
                hi_q    <= '0;
                lo_q    <= mag1;
                mcand_q <= mag2;
                neg_q   <= op1_neg ^ op2_neg;
                neg_r   <= op1_neg;
                state_q <= S_CALC;
              end
            end else begin
`ifdef MULDIV_FAST_MUL_EN
              {hi_q, lo_q} <= fast_prod;
              neg_q        <= 1'b0;
              neg_r        <= 1'b0;
              state_q      <= S_DONE;
`else
              hi_q    <= '0;
              lo_q    <= mag2;
              mcand_q <= mag1;
              neg_q   <= op1_neg ^ op2_neg;
              neg_r   <= 1'b0;
              state_q <= S_CALC;
`endif
            end
          end
        end

        S_CALC: begin
          if (flush_i) begin
            state_q <= S_IDLE;
          end else begin
            if (is_div_op(op_q)) begin
              if (div_ok) begin
                hi_q <= div_trial[W-1:0];
                lo_q <= {lo_q[W-2:0], 1'b1};
              end else begin
                hi_q <= {hi_q[W-2:0], lo_q[W-1]};
                lo_q <= {lo_q[W-2:0], 1'b0};
              end
            end else begin
              // Multiplier bits are consumed from lo_q[0] while product bits
              // shift in from the top, so {hi,lo} ends as the full product.
              if (lo_q[0]) begin
                {hi_q, lo_q} <= {mul_sum, lo_q[W-1:1]};
              end else begin
                {hi_q, lo_q} <= {1'b0, hi_q, lo_q[W-1:1]};
              end
            end
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_W'(W - 1)) begin
              state_q <= S_DONE;
            end
          end
        end

        S_DONE: begin
          if (!flush_i) begin
            result_o <= result_next;
            done_o   <= 1'b1;
          end
          state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
